intv_cart_loader: RTL and testbench

//  Cartridge image loader downstream of hps_io's ioctl download stream, upstream of the cart word RAM in intv_core.

---
 rtl/intv_pkg.sv | 49 ++++
 rtl/intv_cart_loader_if.sv | 26 ++
 rtl/intv_crc16.sv | 13 +
 rtl/intv_cart_loader.sv | 268 ++++++++++++++++++++++++++
 tb/tb_intv_cart_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intv_pkg.sv
// Shared types and constants for the Intellivision cartridge loader.
//  ldr_state_e   loader FSM states
//  CRC_POLY/INIT CRC-16 parameters used by Intellicart segment checks
//  IC_MAGIC      first byte of an Intellicart (.ROM) image
//  IC_TABLE_LEN  trailing enable table: 48 bytes plus 2 unchecked CRC bytes
//  crc16_byte    one byte of MSB-first CRC-16
package intv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,   // waiting for the first byte (acts as the magic-byte state)
        ST_RAW    = 4'd1,
        ST_HDR1   = 4'd2,   // expecting segment count n
        ST_HDR2   = 4'd3,   // expecting n ^ 8'hFF
        ST_SEG_LO = 4'd4,
        ST_SEG_HI = 4'd5,
        ST_DATA   = 4'd6,
        ST_CRC_H  = 4'd7,
        ST_CRC_L  = 4'd8,
        ST_TABLE  = 4'd9,
        ST_DONE   = 4'd10,
        ST_ERROR  = 4'd11
    } ldr_state_e;

    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [7:0]  IC_MAGIC     = 8'hA8;
    localparam logic [5:0]  IC_TABLE_LEN = 6'd50;

    localparam logic [1:0]  ERR_NONE  = 2'd0;
    localparam logic [1:0]  ERR_HDR   = 2'd1;
    localparam logic [1:0]  ERR_CRC   = 2'd2;
    localparam logic [1:0]  ERR_TRUNC = 2'd3;

    // Feed one byte, MSB first, into a CRC-16 register.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // The first error reported in a load is the one that sticks.
    function automatic logic [1:0] first_err(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur != ERR_NONE) ? cur : nxt;
    endfunction

endpackage

// File: rtl/intv_cart_loader_if.sv
// Download-stream and cart-RAM write bus of the cartridge loader.
//  ioctl_download/index/wr/dout  byte stream from hps_io
//  ioctl_wait                    stall request back to hps_io
//  mem_wr/addr/data, mem_rdy     16-bit word write handshake to cart RAM
// The loader uses the slave modport; the environment (hps_io + RAM) uses master.
interface intv_cart_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_rdy;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, mem_rdy,
        input  ioctl_wait, mem_wr, mem_addr, mem_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, mem_rdy,
        output ioctl_wait, mem_wr, mem_addr, mem_data
    );
endinterface

// File: rtl/intv_crc16.sv
// Combinational byte-wide CRC-16 step.
//  crc_in   current CRC register
//  data_in  next byte
//  crc_out  CRC after absorbing data_in
module intv_crc16
    import intv_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);
    assign crc_out = crc16_byte(crc_in, data_in);
endmodule

// File: rtl/intv_cart_loader.sv
// Cartridge image loader: turns the hps_io byte stream into 16-bit cart RAM
// word writes. Raw images are packed big-endian from RAW_BASE; Intellicart
// images are parsed segment by segment with a CRC-16 check per segment.
//  clk_sys, reset  system clock, synchronous active-high reset
//  format          0 auto, 1 raw, 2 Intellicart, 3 raw
//  bus             download stream in, word writes out (slave modport)
//  page_valid      bit p set once any word is written into 0xp000-0xpFFF
//  load_done       high from the end of a download until the next start
//  load_err        0 ok, 1 bad header, 2 CRC mismatch, 3 truncated
module intv_cart_loader
    import intv_pkg::*;
#(
    parameter logic [7:0]  IDX_ROM  = 8'd0,
    parameter logic [15:0] RAW_BASE = 16'h0000
)
(
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [1:0]         format,
    intv_cart_loader_if.slave  bus,
    output logic [15:0]        page_valid,
    output logic               load_done,
    output logic [1:0]         load_err
);

    ldr_state_e  state_r, state_n;
    logic        dl_prev_r, dl_prev_n;
    logic        active_r, active_n;        // bytes belong to the current image
    logic [7:0]  hi_r, hi_n;
    logic        hi_valid_r, hi_valid_n;
    logic [15:0] addr_r, addr_n;            // address of the next word to issue
    logic [16:0] cnt_r, cnt_n;              // words left in the segment
    logic [7:0]  seg_left_r, seg_left_n;
    logic [7:0]  n_r, n_n;
    logic [7:0]  seg_start_r, seg_start_n;
    logic [7:0]  seg_end_r, seg_end_n;
    logic [15:0] crc_r, crc_n;
    logic [7:0]  crc_hi_r, crc_hi_n;
    logic [5:0]  tbl_cnt_r, tbl_cnt_n;
    logic        hdr_latch_r, hdr_latch_n;
    logic        tail_r, tail_n;            // odd raw byte still to be written
    logic        mem_wr_r, mem_wr_n;
    logic [15:0] mem_addr_r, mem_addr_n;
    logic [15:0] mem_data_r, mem_data_n;
    logic [15:0] page_valid_r, page_valid_n;
    logic        load_done_r, load_done_n;
    logic [1:0]  load_err_r, load_err_n;

    logic        wait_s, byte_s, rise_s, fall_s, slot_free_s, end_ok_s;
    logic [15:0] crc_step_s;
    logic [8:0]  seg_pages_s;

    intv_crc16 u_crc (
        .crc_in  (crc_r),
        .data_in (bus.ioctl_dout),
        .crc_out (crc_step_s)
    );

    // Wait must drop in the same cycle mem_rdy arrives, so it is decoded from mem_rdy directly.
    assign wait_s      = (mem_wr_r & ~bus.mem_rdy) | hdr_latch_r;
    assign byte_s      = active_r & bus.ioctl_wr & ~wait_s;
    assign rise_s      = bus.ioctl_download & ~dl_prev_r & (bus.ioctl_index == IDX_ROM);
    assign fall_s      = ~bus.ioctl_download & dl_prev_r & active_r;
    assign slot_free_s = ~mem_wr_r | bus.mem_rdy;
    assign seg_pages_s = {1'b0, seg_end_r} - {1'b0, seg_start_r} + 9'd1;
    assign end_ok_s    = (state_r == ST_DONE) || (state_r == ST_RAW) || (state_r == ST_ERROR) ||
                         ((state_r == ST_IDLE) && (format != 2'd2));

    // Next-state and datapath decode for the whole loader.
    always_comb begin
        state_n      = state_r;      dl_prev_n    = bus.ioctl_download;
        active_n     = active_r;     hi_n         = hi_r;
        hi_valid_n   = hi_valid_r;   addr_n       = addr_r;
        cnt_n        = cnt_r;        seg_left_n   = seg_left_r;
        n_n          = n_r;          seg_start_n  = seg_start_r;
        seg_end_n    = seg_end_r;    crc_n        = crc_r;
        crc_hi_n     = crc_hi_r;     tbl_cnt_n    = tbl_cnt_r;
        hdr_latch_n  = hdr_latch_r;  tail_n       = tail_r;
        mem_wr_n     = mem_wr_r;     mem_addr_n   = mem_addr_r;
        mem_data_n   = mem_data_r;   page_valid_n = page_valid_r;
        load_done_n  = load_done_r;  load_err_n   = load_err_r;

        if (mem_wr_r && bus.mem_rdy) begin
            mem_wr_n = 1'b0;
            page_valid_n[mem_addr_r[15:12]] = 1'b1;
        end else begin
            mem_wr_n = mem_wr_r;
        end

        if (tail_r && slot_free_s) begin
            mem_wr_n   = 1'b1;
            mem_addr_n = addr_r;
            mem_data_n = {hi_r, 8'h00};
            addr_n     = addr_r + 16'd1;
            tail_n     = 1'b0;
            hi_valid_n = 1'b0;
        end else begin
            tail_n = tail_r;
        end

        if (rise_s) begin
            active_n     = 1'b1;
            state_n      = ST_IDLE;
            page_valid_n = 16'h0000;
            load_done_n  = 1'b0;
            load_err_n   = ERR_NONE;
            hi_valid_n   = 1'b0;
            addr_n       = RAW_BASE;
            tail_n       = 1'b0;
            hdr_latch_n  = 1'b0;
        end else if (fall_s) begin
            active_n    = 1'b0;
            load_done_n = 1'b1;
            hdr_latch_n = 1'b0;
            load_err_n  = end_ok_s ? load_err_r : first_err(load_err_r, ERR_TRUNC);
            tail_n      = (state_r == ST_RAW) && hi_valid_r;
        end else if (hdr_latch_r) begin
            // Segment bounds were captured last cycle; set up the data run.
            hdr_latch_n = 1'b0;
            if (seg_end_r < seg_start_r) begin
                state_n    = ST_ERROR;
                load_err_n = first_err(load_err_r, ERR_HDR);
            end else begin
                addr_n = {seg_start_r, 8'h00};
                cnt_n  = {seg_pages_s, 8'h00};
            end
        end else if (byte_s) begin
            case (state_r)
                ST_IDLE: begin
                    if ((bus.ioctl_dout == IC_MAGIC) && (format != 2'd1) && (format != 2'd3)) begin
                        state_n = ST_HDR1;
                    end else if (format == 2'd2) begin
                        state_n    = ST_ERROR;
                        load_err_n = first_err(load_err_r, ERR_HDR);
                    end else begin
                        // Auto-detected raw: the byte just seen is the first hi byte.
                        state_n    = ST_RAW;
                        hi_n       = bus.ioctl_dout;
                        hi_valid_n = 1'b1;
                    end
                end
                ST_RAW: begin
                    if (hi_valid_r) begin
                        mem_wr_n   = 1'b1;
                        mem_addr_n = addr_r;
                        mem_data_n = {hi_r, bus.ioctl_dout};
                        addr_n     = addr_r + 16'd1;
                        hi_valid_n = 1'b0;
                    end else begin
                        hi_n       = bus.ioctl_dout;
                        hi_valid_n = 1'b1;
                    end
                end
                ST_HDR1: begin
                    n_n     = bus.ioctl_dout;
                    state_n = ST_HDR2;
                end
                ST_HDR2: begin
                    if (bus.ioctl_dout != ~n_r) begin
                        state_n    = ST_ERROR;
                        load_err_n = first_err(load_err_r, ERR_HDR);
                    end else if (n_r == 8'd0) begin
                        state_n   = ST_TABLE;
                        tbl_cnt_n = 6'd0;
                    end else begin
                        state_n    = ST_SEG_LO;
                        seg_left_n = n_r;
                        crc_n      = CRC_INIT;
                    end
                end
                ST_SEG_LO: begin
                    seg_start_n = bus.ioctl_dout;
                    crc_n       = crc_step_s;
                    state_n     = ST_SEG_HI;
                end
                ST_SEG_HI: begin
                    seg_end_n   = bus.ioctl_dout;
                    crc_n       = crc_step_s;
                    hdr_latch_n = 1'b1;
                    hi_valid_n  = 1'b0;
                    state_n     = ST_DATA;
                end
                ST_DATA: begin
                    crc_n = crc_step_s;
                    if (hi_valid_r) begin
                        mem_wr_n   = 1'b1;
                        mem_addr_n = addr_r;
                        mem_data_n = {hi_r, bus.ioctl_dout};
                        addr_n     = addr_r + 16'd1;
                        cnt_n      = cnt_r - 17'd1;
                        hi_valid_n = 1'b0;
                        state_n    = (cnt_r == 17'd1) ? ST_CRC_H : ST_DATA;
                    end else begin
                        hi_n       = bus.ioctl_dout;
                        hi_valid_n = 1'b1;
                    end
                end
                ST_CRC_H: begin
                    crc_hi_n = bus.ioctl_dout;
                    state_n  = ST_CRC_L;
                end
                ST_CRC_L: begin
                    // A bad CRC is reported but the remaining segments still load.
                    if ({crc_hi_r, bus.ioctl_dout} != crc_r) begin
                        load_err_n = first_err(load_err_r, ERR_CRC);
                    end else begin
                        load_err_n = load_err_r;
                    end
                    seg_left_n = seg_left_r - 8'd1;
                    if (seg_left_r == 8'd1) begin
                        state_n   = ST_TABLE;
                        tbl_cnt_n = 6'd0;
                    end else begin
                        state_n = ST_SEG_LO;
                        crc_n   = CRC_INIT;
                    end
                end
                ST_TABLE: begin
                    tbl_cnt_n = tbl_cnt_r + 6'd1;
                    state_n   = (tbl_cnt_r == (IC_TABLE_LEN - 6'd1)) ? ST_DONE : ST_TABLE;
                end
                default: begin
                    state_n = state_r;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State and datapath registers; dl_prev resets high so a download already in progress is not seen as a new start.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= ST_IDLE;   dl_prev_r    <= 1'b1;
            active_r     <= 1'b0;      hi_r         <= 8'h00;
            hi_valid_r   <= 1'b0;      addr_r       <= 16'h0000;
            cnt_r        <= 17'd0;     seg_left_r   <= 8'h00;
            n_r          <= 8'h00;     seg_start_r  <= 8'h00;
            seg_end_r    <= 8'h00;     crc_r        <= 16'h0000;
            crc_hi_r     <= 8'h00;     tbl_cnt_r    <= 6'd0;
            hdr_latch_r  <= 1'b0;      tail_r       <= 1'b0;
            mem_wr_r     <= 1'b0;      mem_addr_r   <= 16'h0000;
            mem_data_r   <= 16'h0000;  page_valid_r <= 16'h0000;
            load_done_r  <= 1'b0;      load_err_r   <= ERR_NONE;
        end else begin
            state_r      <= state_n;      dl_prev_r    <= dl_prev_n;
            active_r     <= active_n;     hi_r         <= hi_n;
            hi_valid_r   <= hi_valid_n;   addr_r       <= addr_n;
            cnt_r        <= cnt_n;        seg_left_r   <= seg_left_n;
            n_r          <= n_n;          seg_start_r  <= seg_start_n;
            seg_end_r    <= seg_end_n;    crc_r        <= crc_n;
            crc_hi_r     <= crc_hi_n;     tbl_cnt_r    <= tbl_cnt_n;
            hdr_latch_r  <= hdr_latch_n;  tail_r       <= tail_n;
            mem_wr_r     <= mem_wr_n;     mem_addr_r   <= mem_addr_n;
            mem_data_r   <= mem_data_n;   page_valid_r <= page_valid_n;
            load_done_r  <= load_done_n;  load_err_r   <= load_err_n;
        end
    end

    assign bus.ioctl_wait = wait_s;
    assign bus.mem_wr     = mem_wr_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_data   = mem_data_r;
    assign page_valid     = page_valid_r;
    assign load_done      = load_done_r;
    assign load_err       = load_err_r;

endmodule

// File: tb/tb_intv_cart_loader.sv
// Directed self-checking bench for intv_cart_loader: raw packing, auto
// detection, Intellicart parsing with CRC, header errors, stalls,
// truncation and reset during a load.
module tb_intv_cart_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  format;
    logic [15:0] page_valid;
    logic        load_done;
    logic [1:0]  load_err;

    intv_cart_loader_if bus();

    intv_cart_loader #(
        .IDX_ROM  (8'd0),
        .RAW_BASE (16'h0000)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .format     (format),
        .bus        (bus.slave),
        .page_valid (page_valid),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wait_cycles = 0;
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [7:0]  img_q[$];
    int          base;
    int          w0;

    // Log every accepted word write and count stall cycles, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (!reset && bus.mem_wr && bus.mem_rdy) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_data);
        end
        if (bus.ioctl_wait) wait_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input int idx, input logic [15:0] a, input logic [15:0] d);
        if (idx >= wr_addr_q.size()) begin
            check_eq("wr_missing", 32'(wr_addr_q.size()), 32'(idx + 1));
        end else begin
            check_eq("wr_addr", 32'(wr_addr_q[idx]), 32'(a));
            check_eq("wr_data", 32'(wr_data_q[idx]), 32'(d));
        end
    endtask

    // Bit-serial reference CRC-16 (poly 1021, MSB first).
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        while (bus.ioctl_wait && guard < 200) begin
            @(posedge clk_sys); #1;
            guard++;
        end
        if (guard >= 200) check_eq("wait_timeout", 32'(bus.ioctl_wait), 32'd0);
        bus.ioctl_dout = b;
        bus.ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic end_dl();
        repeat (4) @(posedge clk_sys);
        #1 bus.ioctl_download = 1'b0;
        repeat (8) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_img();
        foreach (img_q[i]) send_byte(img_q[i]);
    endtask

    // One-segment image covering 0x5000-0x50FF; data byte k = k ^ 5A.
    task automatic build_ic(input bit bad_crc);
        logic [15:0] crc;
        logic [7:0]  d;
        img_q.delete();
        crc = 16'hFFFF;
        img_q.push_back(8'hA8); img_q.push_back(8'h01); img_q.push_back(8'hFE);
        img_q.push_back(8'h50); crc = crc_bits(crc, 8'h50);
        img_q.push_back(8'h50); crc = crc_bits(crc, 8'h50);
        for (int k = 0; k < 512; k++) begin
            d = 8'(k) ^ 8'h5A;
            img_q.push_back(d);
            crc = crc_bits(crc, d);
        end
        img_q.push_back(crc[15:8]);
        img_q.push_back(bad_crc ? ~crc[7:0] : crc[7:0]);
        for (int k = 0; k < 50; k++) img_q.push_back(8'h00);
    endtask

    task automatic check_ic_writes(input int b);
        check_eq("ic_count", 32'(wr_addr_q.size() - b), 32'd256);
        for (int j = 0; j < 256; j++)
            check_wr(b + j, 16'h5000 + 16'(j), {8'(2 * j) ^ 8'h5A, 8'(2 * j + 1) ^ 8'h5A});
    endtask

    initial begin
        reset = 1'b1; format = 2'd1;
        bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0;
        bus.ioctl_wr = 1'b0; bus.ioctl_dout = 8'h00; bus.mem_rdy = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check_eq("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        check_eq("rst_page", 32'(page_valid), 32'd0);
        check_eq("rst_done", 32'(load_done), 32'd0);
        check_eq("rst_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;

        // T1 raw with odd trailing byte
        base = wr_addr_q.size(); format = 2'd1;
        start_dl(8'd0);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        end_dl();
        check_eq("t1_count", 32'(wr_addr_q.size() - base), 32'd2);
        check_wr(base, 16'h0000, 16'h1234);
        check_wr(base + 1, 16'h0001, 16'h5600);
        check_eq("t1_page", 32'(page_valid), 32'h0001);
        check_eq("t1_done", 32'(load_done), 32'd1);
        check_eq("t1_err", 32'(load_err), 32'd0);

        // Other download index is ignored
        base = wr_addr_q.size();
        start_dl(8'd3);
        send_byte(8'h77); send_byte(8'h88);
        end_dl();
        check_eq("idx_count", 32'(wr_addr_q.size() - base), 32'd0);

        // Auto detect falls back to raw without losing the first byte
        base = wr_addr_q.size(); format = 2'd0;
        start_dl(8'd0);
        check_eq("auto_start_done", 32'(load_done), 32'd0);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        end_dl();
        check_eq("auto_count", 32'(wr_addr_q.size() - base), 32'd2);
        check_wr(base, 16'h0000, 16'h9ABC);
        check_wr(base + 1, 16'h0001, 16'hDEF0);

        // T2 auto-detected Intellicart image
        build_ic(1'b0);
        base = wr_addr_q.size(); format = 2'd0;
        start_dl(8'd0);
        send_img();
        end_dl();
        check_ic_writes(base);
        check_eq("t2_page", 32'(page_valid), 32'h0020);
        check_eq("t2_done", 32'(load_done), 32'd1);
        check_eq("t2_err", 32'(load_err), 32'd0);

        // T3 bad header complement
        base = wr_addr_q.size(); format = 2'd0;
        start_dl(8'd0);
        send_byte(8'hA8); send_byte(8'h02); send_byte(8'hFE);
        send_byte(8'h50); send_byte(8'h50); send_byte(8'h11); send_byte(8'h22);
        end_dl();
        check_eq("t3_count", 32'(wr_addr_q.size() - base), 32'd0);
        check_eq("t3_err", 32'(load_err), 32'd1);
        check_eq("t3_page", 32'(page_valid), 32'd0);

        // T4 CRC mismatch still loads every word
        build_ic(1'b1);
        base = wr_addr_q.size(); format = 2'd2;
        start_dl(8'd0);
        send_img();
        end_dl();
        check_ic_writes(base);
        check_eq("t4_err", 32'(load_err), 32'd2);
        check_eq("t4_done", 32'(load_done), 32'd1);

        // Zero segments: header then table only
        base = wr_addr_q.size(); format = 2'd2;
        start_dl(8'd0);
        send_byte(8'hA8); send_byte(8'h00); send_byte(8'hFF);
        for (int k = 0; k < 50; k++) send_byte(8'h33);
        end_dl();
        check_eq("n0_count", 32'(wr_addr_q.size() - base), 32'd0);
        check_eq("n0_err", 32'(load_err), 32'd0);
        check_eq("n0_done", 32'(load_done), 32'd1);

        // T5 five-cycle stall on the third word, with a stray byte during the stall
        base = wr_addr_q.size(); format = 2'd1;
        start_dl(8'd0);
        w0 = wait_cycles;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        bus.mem_rdy = 1'b0;
        send_byte(8'h66);
        @(posedge clk_sys); #1 bus.ioctl_dout = 8'hEE; bus.ioctl_wr = 1'b1;
        @(posedge clk_sys); #1 bus.ioctl_wr = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 bus.mem_rdy = 1'b1;
        send_byte(8'h77); send_byte(8'h88);
        end_dl();
        check_eq("t5_wait_cycles", 32'(wait_cycles - w0), 32'd5);
        check_eq("t5_count", 32'(wr_addr_q.size() - base), 32'd4);
        check_wr(base, 16'h0000, 16'h1122);
        check_wr(base + 1, 16'h0001, 16'h3344);
        check_wr(base + 2, 16'h0002, 16'h5566);
        check_wr(base + 3, 16'h0003, 16'h7788);

        // T6 truncation in the middle of segment data
        format = 2'd0;
        start_dl(8'd0);
        send_byte(8'hA8); send_byte(8'h01); send_byte(8'hFE); send_byte(8'h50); send_byte(8'h50);
        for (int k = 0; k < 10; k++) send_byte(8'(k));
        end_dl();
        check_eq("t6_err", 32'(load_err), 32'd3);
        check_eq("t6_done", 32'(load_done), 32'd1);

        // Reset in the middle of a raw load, then stray bytes
        format = 2'd1;
        start_dl(8'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        check_eq("rs_page", 32'(page_valid), 32'd0);
        check_eq("rs_done", 32'(load_done), 32'd0);
        check_eq("rs_err", 32'(load_err), 32'd0);
        check_eq("rs_mem_wr", 32'(bus.mem_wr), 32'd0);
        base = wr_addr_q.size();
        send_byte(8'h04); send_byte(8'h05);
        end_dl();
        check_eq("rs_ignored", 32'(wr_addr_q.size() - base), 32'd0);
        check_eq("rs_done_after", 32'(load_done), 32'd0);

        // A fresh download after reset loads normally
        base = wr_addr_q.size();
        start_dl(8'd0);
        send_byte(8'hAB); send_byte(8'hCD);
        end_dl();
        check_eq("rs_new_count", 32'(wr_addr_q.size() - base), 32'd1);
        check_wr(base, 16'h0000, 16'hABCD);
        check_eq("rs_new_done", 32'(load_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
